// File: rtl/n0_pkg.sv
// n0_pkg: shared defaults and mode encodings for the n0 multiplier array.
//   N_DEF     default signed fixed-point data width
//   TN_DEF    default number of multiplier lanes
//   FRAC_DEF  default fractional bits
//   LAT_DEF   default pipeline depth in register stages
//   MODE_*    per-beat arithmetic mode encodings
package n0_pkg;
    localparam int N_DEF    = 16;
    localparam int TN_DEF   = 16;
    localparam int FRAC_DEF = 8;
    localparam int LAT_DEF  = 3;
    localparam logic MODE_TRUNC  = 1'b0;
    localparam logic MODE_RNDSAT = 1'b1;
endpackage

// File: rtl/n0_lane_fxmul.sv
// n0_lane_fxmul: one fixed-point multiplier lane, LAT register stages deep.
//   clk, rst  clock and synchronous active-high reset (output stage only)
//   adv       pipeline advance enable; all stages hold when low
//   ld        valid bit of the stage feeding the output register
//   a, b      signed Q(N-FRAC).FRAC operands
//   mode      0 truncate/wrap, 1 round-half-up and saturate
//   res, nz   registered lane result and its nonzero flag
module n0_lane_fxmul
    import n0_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int LAT  = LAT_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    input  logic         ld,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         mode,
    output logic [N-1:0] res,
    output logic         nz
);
    localparam logic signed [2*N:0] HALF = (2*N+1)'(1) << (FRAC-1);
    localparam logic signed [2*N:0] MAXV = {{(N+2){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N:0] MINV = {{(N+2){1'b1}}, {(N-1){1'b0}}};

    logic signed [N-1:0]   a_q, b_q;
    logic                  m_q;
    logic signed [2*N-1:0] p0, pl;
    logic                  ml;
    logic signed [2*N:0]   rs, sh;
    logic [N-1:0]          trn, rnd, nxt;

    always_ff @(posedge clk) begin
        if (adv) begin
            a_q <= a;
            b_q <= b;
            m_q <= mode;
        end
    end

    assign p0 = a_q * b_q;

    // Middle stages only delay the full product; LAT=2 has none.
    generate
        if (LAT == 2) begin : g_direct
            assign pl = p0;
            assign ml = m_q;
        end else begin : g_pipe
            logic signed [2*N-1:0] pp [LAT-2];
            logic                  mp [LAT-2];
            always_ff @(posedge clk) begin
                if (adv) begin
                    pp[0] <= p0;
                    mp[0] <= m_q;
                    for (int i = 1; i < LAT - 2; i++) begin
                        pp[i] <= pp[i-1];
                        mp[i] <= mp[i-1];
                    end
                end
            end
            assign pl = pp[LAT-3];
            assign ml = mp[LAT-3];
        end
    endgenerate

    // One guard bit keeps the rounding add from overflowing the product.
    assign rs  = {pl[2*N-1], pl} + HALF;
    assign sh  = $signed(rs) >>> FRAC;
    assign rnd = sh > MAXV ? MAXV[N-1:0] : sh < MINV ? MINV[N-1:0] : sh[N-1:0];
    assign trn = pl[FRAC+N-1:FRAC];
    assign nxt = (ml == MODE_RNDSAT) ? rnd : trn;

    // Bubbles never overwrite the output, so it stays 0 until the first real beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
            nz  <= 1'b0;
        end else if (adv && ld) begin
            res <= nxt;
            nz  <= |nxt;
        end
    end
endmodule

// File: rtl/n0_mult_array.sv
// n0_mult_array: TN-lane broadcast fixed-point multiplier with valid/ready flow control.
//   clk, rst          clock and synchronous active-high reset
//   i_valid, o_ready  input handshake; o_ready is the global advance enable
//   i_nbin            neuron value broadcast to all lanes
//   i_sb              TN packed synapse values, lane k at [k*N +: N]
//   i_mode            0 truncate/wrap, 1 round-half-up and saturate (per beat)
//   o_valid, i_ready  output handshake
//   o_res             TN packed lane results
//   o_nz              per-lane nonzero flags
module n0_mult_array
    import n0_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int TN   = TN_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int LAT  = LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [N-1:0]  i_nbin,
    input  logic [TN*N-1:0] i_sb,
    input  logic          i_mode,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [TN*N-1:0] o_res,
    output logic [TN-1:0] o_nz
);
    logic [LAT-1:0] v;
    logic           adv;

    // Reset empties the pipeline, so the block is ready throughout it.
    assign adv     = i_ready || !o_valid || rst;
    assign o_ready = adv;
    assign o_valid = v[LAT-1];

    always_ff @(posedge clk) begin
        if (rst)
            v <= '0;
        else if (adv)
            v <= {v[LAT-2:0], i_valid};
    end

    generate
        for (genvar k = 0; k < TN; k++) begin : g_lane
            n0_lane_fxmul #(.N(N), .FRAC(FRAC), .LAT(LAT)) u_lane (
                .clk  (clk),
                .rst  (rst),
                .adv  (adv),
                .ld   (v[LAT-2]),
                .a    (i_nbin),
                .b    (i_sb[k*N +: N]),
                .mode (i_mode),
                .res  (o_res[k*N +: N]),
                .nz   (o_nz[k])
            );
        end
    endgenerate
endmodule

// File: tb/tb_n0_mult_array.sv
// tb_n0_mult_array: self-checking bench for n0_mult_array (N=16, TN=16, FRAC=8, LAT=3).
module tb_n0_mult_array;
    localparam int N = 16, TN = 16, FRAC = 8, LAT = 3;

    typedef struct {
        logic [15:0] nbin;
        logic [15:0] sb;
        logic        mode;
        logic [15:0] exp;
        logic        nz;
    } vec_t;

    typedef struct {
        logic [TN*N-1:0] res;
        logic [TN-1:0]   nz;
    } exp_t;

    logic clk = 0;
    logic rst, i_valid, o_ready, i_mode, o_valid, i_ready;
    logic [N-1:0] i_nbin;
    logic [TN*N-1:0] i_sb, o_res, stall_res;
    logic [TN-1:0] o_nz, stall_nz;
    logic stall_v = 0;

    int tests = 0, fails = 0, lat, sent, nvalid, n;
    logic acc;
    exp_t q[$];
    exp_t e;
    vec_t vt[9];
    logic [15:0] got[6];

    always #5 clk = ~clk;

    n0_mult_array #(.N(N), .TN(TN), .FRAC(FRAC), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_nbin(i_nbin), .i_sb(i_sb), .i_mode(i_mode), .o_valid(o_valid),
        .i_ready(i_ready), .o_res(o_res), .o_nz(o_nz)
    );

    task automatic chk(input string name, input logic [255:0] got_v, input logic [255:0] exp_v);
        tests++;
        if (got_v !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got_v, exp_v);
        end
    endtask

    // Reference: plain integer fixed-point arithmetic.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic m);
        longint p, r;
        p = longint'($signed(a)) * longint'($signed(b));
        if (m) begin
            r = (p + (longint'(1) << (FRAC - 1))) >>> FRAC;
            if (r > 32767) r = 32767;
            if (r < -32768) r = -32768;
        end else
            r = p >>> FRAC;
        return 16'(r);
    endfunction

    function automatic exp_t model(input logic [15:0] a, input logic [TN*N-1:0] sb, input logic m);
        exp_t x;
        for (int k = 0; k < TN; k++) begin
            x.res[k*N +: N] = ref_mul(a, sb[k*N +: N], m);
            x.nz[k] = (x.res[k*N +: N] != 0);
        end
        return x;
    endfunction

    // Scoreboard monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            stall_v = 0;
        end else begin
            if (stall_v) begin
                chk("stall_valid", o_valid, 1);
                chk("stall_res", o_res, stall_res);
                chk("stall_nz", o_nz, stall_nz);
            end
            if (o_valid && i_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_res", o_res, e.res);
                    chk("sb_nz", o_nz, e.nz);
                end
            end
            stall_v   = o_valid && !i_ready;
            stall_res = o_res;
            stall_nz  = o_nz;
            if (i_valid && o_ready) q.push_back(model(i_nbin, i_sb, i_mode));
        end
    end

    task automatic rand_beat();
        i_nbin = 16'($urandom);
        for (int k = 0; k < TN * N / 32; k++) i_sb[k*32 +: 32] = $urandom;
        i_mode = 1'($urandom % 2);
    endtask

    task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic m, output int l);
        i_valid = 1; i_nbin = a; i_sb = {TN{b}}; i_mode = m;
        @(posedge clk); #1;
        i_valid = 0;
        l = 1;
        while (!o_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        vt[0] = '{16'h0180, 16'h0200, 1'b0, 16'h0300, 1'b1};
        vt[1] = '{16'h7F00, 16'h0200, 1'b0, 16'hFE00, 1'b1};
        vt[2] = '{16'h7F00, 16'h0200, 1'b1, 16'h7FFF, 1'b1};
        vt[3] = '{16'h8000, 16'h0200, 1'b1, 16'h8000, 1'b1};
        vt[4] = '{16'h0001, 16'h0080, 1'b0, 16'h0000, 1'b0};
        vt[5] = '{16'h0001, 16'h0080, 1'b1, 16'h0001, 1'b1};
        vt[6] = '{16'hFF00, 16'h0100, 1'b0, 16'hFF00, 1'b1};
        vt[7] = '{16'hFFFF, 16'h0080, 1'b0, 16'hFFFF, 1'b1};
        vt[8] = '{16'hFFFF, 16'h0080, 1'b1, 16'h0000, 1'b0};

        rst = 1; i_valid = 1; i_ready = 0; i_nbin = 16'h1234; i_sb = '1; i_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_ready", o_ready, 1);
        i_valid = 0; i_ready = 1;
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        chk("post_rst_valid", o_valid, 0);
        chk("post_rst_res", o_res, 0);
        chk("post_rst_nz", o_nz, 0);

        foreach (vt[i]) begin
            send_one(vt[i].nbin, vt[i].sb, vt[i].mode, lat);
            chk($sformatf("vec%0d_latency", i), lat, LAT);
            chk($sformatf("vec%0d_res", i), o_res, {TN{vt[i].exp}});
            chk($sformatf("vec%0d_nz", i), o_nz, vt[i].nz ? {TN{1'b1}} : {TN{1'b0}});
            repeat (2) @(posedge clk);
            #1;
        end

        sent = 0;
        rand_beat();
        i_valid = 1;
        i_ready = 1'($urandom % 2);
        for (int c = 0; c < 400 && sent < 20; c++) begin
            @(negedge clk);
            acc = i_valid && o_ready;
            @(posedge clk); #1;
            i_ready = 1'($urandom % 2);
            if (acc) begin
                sent++;
                if (sent < 20) rand_beat(); else i_valid = 0;
            end
        end
        i_valid = 0;
        chk("stream_accepted", sent, 20);
        for (int c = 0; c < 200 && q.size() != 0; c++) begin
            @(posedge clk); #1;
            i_ready = 1'($urandom % 2);
        end
        i_ready = 1;
        @(posedge clk); #1;
        chk("stream_drained", q.size(), 0);

        i_ready = 0;
        for (int b = 0; b < 3; b++) begin
            i_valid = 1; rand_beat();
            @(posedge clk); #1;
        end
        i_valid = 0;
        rst = 1;
        #1;
        chk("mid_rst_o_ready", o_ready, 1);
        @(posedge clk); #1;
        rst = 0; i_ready = 1;
        nvalid = 0;
        for (int c = 0; c < 10; c++) begin
            if (o_valid) nvalid++;
            @(posedge clk); #1;
        end
        chk("rst_flush_no_valid", nvalid, 0);
        send_one(16'h0180, 16'h0200, 1'b0, lat);
        chk("rst_new_latency", lat, LAT);
        chk("rst_new_res", o_res, {TN{16'h0300}});
        repeat (2) @(posedge clk);
        #1;

        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_valid && n < 6) begin
                got[n] = o_res[15:0];
                n++;
            end
            if (c < 6) begin
                i_valid = 1; i_nbin = 16'h7F00; i_sb = {TN{16'h0200}}; i_mode = 1'(c % 2);
            end else
                i_valid = 0;
            @(posedge clk); #1;
        end
        chk("alt_count", n, 6);
        for (int b = 0; b < 6; b++)
            chk($sformatf("alt_beat%0d", b), got[b], (b % 2) ? 16'h7FFF : 16'hFE00);

        repeat (3) @(posedge clk);
        #1;
        chk("final_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
